// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: one SEG_W-bit adder slice shared by NUM_REQ requesters.
// A round-robin arbiter grants one requester at a time. Each granted add or
// sub is worked through LSB segment first, keeping the carry in a register
// between segments, and the result is held until the owner takes it.
//
// state | meaning
// IDLE  | arbitrating; o_req_ready one-hot to the round-robin winner
// CALC  | adding one segment per cycle, carry held in r_carry
// RESP  | result valid to owner r_id, held until i_rsp_ready[r_id]
module adder_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int SEG_W   = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ-1:0]          i_req_sub,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_b,
  output logic [NUM_REQ-1:0]          o_req_ready,
  output logic [NUM_REQ-1:0]          o_rsp_valid,
  input  logic [NUM_REQ-1:0]          i_rsp_ready,
  output logic [DATA_W-1:0]           o_rsp_data,
  output logic                        o_rsp_carry,
  output logic                        o_busy
);

  localparam int NSEG  = DATA_W / SEG_W;
  localparam int CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int PTR_W = $clog2(NUM_REQ);

  // Parameter sanity: a partial last segment or a single requester is not supported.
  if ((DATA_W % SEG_W) != 0) begin : g_bad_seg
    $error("adder_share_ctrl: DATA_W must be a multiple of SEG_W");
  end
  if (NUM_REQ < 2) begin : g_bad_req
    $error("adder_share_ctrl: NUM_REQ must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [PTR_W-1:0]              r_ptr;
  logic [PTR_W-1:0]              r_id;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_carry;
  logic [NSEG-1:0][SEG_W-1:0]    r_a;
  logic [NSEG-1:0][SEG_W-1:0]    r_b;
  logic [NSEG-1:0][SEG_W-1:0]    r_result;

  logic [NUM_REQ-1:0]            w_grant;
  logic [PTR_W-1:0]              w_grant_idx;
  logic                          w_arb_found;
  logic [PTR_W:0]                w_arb_idx;
  logic                          w_accept;
  logic [PTR_W-1:0]              w_ptr_nxt;
  logic [DATA_W-1:0]             w_sel_a;
  logic [DATA_W-1:0]             w_sel_b;
  logic                          w_sel_sub;
  logic [SEG_W:0]                w_seg_sum;
  logic                          w_last_seg;
  logic                          w_rsp_hs;

  // Round-robin arbiter: first valid requester at or after r_ptr, wrapping.
  // Gated by reset so o_req_ready reads zero while reset is held.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    if (i_rst_n && (r_state == S_IDLE)) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_arb_idx = {1'b0, r_ptr} + (PTR_W+1)'(i);
        if (w_arb_idx >= (PTR_W+1)'(NUM_REQ)) begin
          w_arb_idx = w_arb_idx - (PTR_W+1)'(NUM_REQ);
        end
        if (!w_arb_found && i_req_valid[w_arb_idx[PTR_W-1:0]]) begin
          w_arb_found                      = 1'b1;
          w_grant_idx                      = w_arb_idx[PTR_W-1:0];
          w_grant[w_arb_idx[PTR_W-1:0]]    = 1'b1;
        end
      end
    end
  end

  assign w_accept  = w_arb_found;
  assign w_ptr_nxt = (w_grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : (w_grant_idx + PTR_W'(1));

  // Operand mux: pick the winner's operands and opcode out of the packed buses.
  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == PTR_W'(i)) begin
        w_sel_a   = i_req_a[i*DATA_W +: DATA_W];
        w_sel_b   = i_req_b[i*DATA_W +: DATA_W];
        w_sel_sub = i_req_sub[i];
      end
    end
  end

  // Shared slice: one segment of a + (b^mask) plus the registered carry.
  always_comb begin
    w_seg_sum = {1'b0, r_a[r_cnt]} + {1'b0, r_b[r_cnt]} + {{SEG_W{1'b0}}, r_carry};
  end

  assign w_last_seg = (r_cnt == CNT_W'(NSEG-1));
  assign w_rsp_hs   = (r_state == S_RESP) && i_rsp_ready[r_id];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept)   w_state_nxt = S_CALC;
      S_CALC: if (w_last_seg) w_state_nxt = S_RESP;
      S_RESP: if (w_rsp_hs)   w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: grant, owner-only result valid and busy flag.
  always_comb begin
    o_req_ready = w_grant;
    o_rsp_valid = '0;
    o_busy      = 1'b0;
    case (r_state)
      S_CALC: o_busy = 1'b1;
      S_RESP: begin
        o_busy            = 1'b1;
        o_rsp_valid[r_id] = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: latch operands at accept, then fold one segment per CALC cycle.
  // Subtraction is a + ~b + 1, so the inverted b and carry-in of 1 are set up here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b ^ {DATA_W{w_sel_sub}};
            r_carry <= w_sel_sub;
            r_id    <= w_grant_idx;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= '0;
          end
        end
        S_CALC: begin
          r_result[r_cnt] <= w_seg_sum[SEG_W-1:0];
          r_carry         <= w_seg_sum[SEG_W];
          r_cnt           <= w_last_seg ? '0 : (r_cnt + CNT_W'(1));
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_data  = r_result;
  assign o_rsp_carry = r_carry;

endmodule
